// File: rtl/i2c_reg_arbiter.sv
// Two-port register-file arbiter: I2C side (A) and local host (B) share ctrl 0-3 / status 4-7.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is A-priority with MAX_HOLD fairness.
module i2c_reg_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [2:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_gnt,
    output logic       a_ack,
    output logic       a_err,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [2:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_gnt,
    output logic       b_ack,
    output logic       b_err,
    output logic [7:0] b_rdata,
    output logic [7:0] ctrl_reg0,
    output logic [7:0] ctrl_reg1,
    output logic [7:0] ctrl_reg2,
    output logic [7:0] ctrl_reg3,
    input  logic [7:0] stat_reg4,
    input  logic [7:0] stat_reg5,
    input  logic [7:0] stat_reg6,
    input  logic [7:0] stat_reg7
);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_e;

    state_e     state_q, state_d;
    logic [7:0] ctrl_q [4];
    logic [7:0] rf [8];
    logic       a_ack_q, b_ack_q, a_err_q, b_err_q;
    logic [7:0] a_rdata_q, b_rdata_q;
    logic       win_a;
    logic       g_we;
    logic [2:0] g_addr;
    logic [7:0] g_wdata;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = B was granted last
    logic last_b_q, last_b_d;
    assign win_a = a_req && (!b_req || last_b_q);
`else
    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);
    logic [3:0] hold_q, hold_d;
    assign win_a = a_req && (!b_req || (hold_q < HOLD_LIM));
`endif

    always_comb begin
        rf[0] = ctrl_q[0];
        rf[1] = ctrl_q[1];
        rf[2] = ctrl_q[2];
        rf[3] = ctrl_q[3];
        rf[4] = stat_reg4;
        rf[5] = stat_reg5;
        rf[6] = stat_reg6;
        rf[7] = stat_reg7;
    end

    assign g_we    = (state_q == GNT_B) ? b_we    : a_we;
    assign g_addr  = (state_q == GNT_B) ? b_addr  : a_addr;
    assign g_wdata = (state_q == GNT_B) ? b_wdata : a_wdata;

    always_comb begin
        state_d = state_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_b_d = last_b_q;
`else
        hold_d = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_a) begin
                    state_d = GNT_A;
`ifdef ARB_ROUND_ROBIN_EN
                    last_b_d = 1'b0;
`else
                    hold_d = b_req ? hold_q + 4'd1 : '0;
`endif
                end else if (b_req) begin
                    state_d = GNT_B;
`ifdef ARB_ROUND_ROBIN_EN
                    last_b_d = 1'b1;
`else
                    hold_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ctrl_q    <= '{default: '0};
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_b_q  <= 1'b1;
`else
            hold_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_ack_q <= (state_q == GNT_A);
            b_ack_q <= (state_q == GNT_B);
            a_err_q <= (state_q == GNT_A) && a_we && a_addr[2];
            b_err_q <= (state_q == GNT_B) && b_we && b_addr[2];
            if (state_q == GNT_A && !a_we)
                a_rdata_q <= rf[a_addr];
            if (state_q == GNT_B && !b_we)
                b_rdata_q <= rf[b_addr];
            if (state_q != IDLE && g_we && !g_addr[2])
                ctrl_q[g_addr[1:0]] <= g_wdata;
`ifdef ARB_ROUND_ROBIN_EN
            last_b_q <= last_b_d;
`else
            hold_q   <= hold_d;
`endif
        end
    end

    assign a_gnt     = (state_q == GNT_A);
    assign b_gnt     = (state_q == GNT_B);
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_err     = a_err_q;
    assign b_err     = b_err_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign ctrl_reg0 = ctrl_q[0];
    assign ctrl_reg1 = ctrl_q[1];
    assign ctrl_reg2 = ctrl_q[2];
    assign ctrl_reg3 = ctrl_q[3];

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Scoreboard bench for i2c_reg_arbiter: a behavioural model predicts grants and responses,
// a monitor pops expected acks. Honours ARB_ROUND_ROBIN_EN like the design.
module tb_i2c_reg_arbiter;

    localparam int unsigned HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [2:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic       a_gnt, a_ack, a_err, b_gnt, b_ack, b_err;
    logic [7:0] a_rdata, b_rdata;
    logic [7:0] c0, c1, c2, c3;
    logic [7:0] st [4];

    i2c_reg_arbiter #(.MAX_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .ctrl_reg0(c0), .ctrl_reg1(c1), .ctrl_reg2(c2), .ctrl_reg3(c3),
        .stat_reg4(st[0]), .stat_reg5(st[1]), .stat_reg6(st[2]), .stat_reg7(st[3])
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         we;
        logic [7:0] rd;
        bit         err;
    } exp_t;

    exp_t       aq[$], bq[$];
    int         gseq[$];
    int         total = 0, bad = 0, cyc = 0;
    bit         started = 0;
    int         pend = 0;      // 0 none, 1 A, 2 B: grant expected in current cycle
    int         streak = 0;    // consecutive A wins while B waited
    bit         last_b = 1;
    logic [7:0] mctrl [4];
    logic [7:0] a_last = '0, b_last = '0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [7:0] mread(logic [2:0] ad);
        return ad < 3'd4 ? mctrl[ad[1:0]] : st[ad - 3'd4];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: arbitration and register effects from the bench's own stimulus
    always @(negedge clk) if (started) begin
        exp_t e;
        check("a_gnt", a_gnt, pend == 1);
        check("b_gnt", b_gnt, pend == 2);
        check("ctrl", {c0, c1, c2, c3}, {mctrl[0], mctrl[1], mctrl[2], mctrl[3]});
        if (a_gnt) gseq.push_back(1);
        if (b_gnt) gseq.push_back(2);
        if (rst) begin
            pend = 0; streak = 0; last_b = 1;
            mctrl = '{default: '0};
        end else if (pend != 0) begin
            e.due = cyc + 1;
            e.we  = (pend == 1) ? a_we : b_we;
            begin
                logic [2:0] ad;
                logic [7:0] wd;
                ad = (pend == 1) ? a_addr : b_addr;
                wd = (pend == 1) ? a_wdata : b_wdata;
                e.rd  = mread(ad);
                e.err = e.we && ad >= 3'd4;
                if (e.we && ad < 3'd4) mctrl[ad[1:0]] = wd;
            end
            if (pend == 1) aq.push_back(e); else bq.push_back(e);
            pend = 0;
        end else if (a_req || b_req) begin
            if (a_req && b_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                pend = last_b ? 1 : 2;
`else
                pend = (streak == HOLD) ? 2 : 1;
`endif
            end else begin
                pend = a_req ? 1 : 2;
            end
            last_b = (pend == 2);
            if (pend == 2 || !b_req) streak = 0; else streak++;
        end
    end

    // Monitor: every ack must match the oldest expected response of that port
    always @(negedge clk) if (started) begin
        exp_t e;
        bit due_a, due_b;
        due_a = aq.size() > 0 && aq[0].due == cyc;
        due_b = bq.size() > 0 && bq[0].due == cyc;
        check("a_ack", a_ack, due_a);
        check("b_ack", b_ack, due_b);
        if (due_a) begin
            e = aq.pop_front();
            if (a_ack) begin
                check("a_err", a_err, e.err);
                if (!e.we) a_last = e.rd;
                check("a_rdata", a_rdata, a_last);
            end
        end
        if (due_b) begin
            e = bq.pop_front();
            if (b_ack) begin
                check("b_err", b_err, e.err);
                if (!e.we) b_last = e.rd;
                check("b_rdata", b_rdata, b_last);
            end
        end
        if (!a_ack) check("a_err_idle", a_err, 0);
        if (!b_ack) check("b_err_idle", b_err, 0);
        if (rst) begin a_last = '0; b_last = '0; end
    end

    task automatic a_xfer(input logic we, input logic [2:0] ad, input logic [7:0] d);
        bit ok = 0;
        a_req = 1; a_we = we; a_addr = ad; a_wdata = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk); #1;
            if (a_gnt) ok = 1;
        end
        if (!ok) check("a_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        a_req = 0;
    endtask

    task automatic b_xfer(input logic we, input logic [2:0] ad, input logic [7:0] d);
        bit ok = 0;
        b_req = 1; b_we = we; b_addr = ad; b_wdata = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk); #1;
            if (b_gnt) ok = 1;
        end
        if (!ok) check("b_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        b_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) st[i] = 8'($urandom);
        mctrl = '{default: '0};
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", {a_gnt, b_gnt}, 0);
        check("rst_ack", {a_ack, b_ack, a_err, b_err}, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        check("rst_ctrl", {c0, c1, c2, c3}, 0);

        // Both ports request from the first cycle after reset and keep requesting
        rst = 0;
        started = 1;
        gseq.delete();
        fork
            while (gseq.size() < 12) a_xfer(0, 3'($urandom), 8'h00);
            while (gseq.size() < 12) b_xfer(0, 3'($urandom), 8'h00);
        join
        for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            check("pattern", gseq[i], (i % 2 == 0) ? 1 : 2);
`else
            check("pattern", gseq[i], (i % 5 == 4) ? 2 : 1);
`endif
        end
        repeat (2) @(posedge clk); #1;

        a_xfer(1, 3'd2, 8'h5A);
        check("ctrl2_5a", c2, 8'h5A);
        b_xfer(0, 3'd2, 8'h00);
        check("b_rd_ack", {b_ack, b_err}, 2'b10);
        check("b_rd_5a", b_rdata, 8'h5A);

        st[2] = 8'h3C;
        b_xfer(1, 3'd6, 8'hFF);
        check("b_ro_err", {b_ack, b_err}, 2'b11);
        a_xfer(0, 3'd6, 8'h00);
        check("a_rd_3c", a_rdata, 8'h3C);
        check("ctrl_kept", {c0, c1, c2, c3}, {8'h00, 8'h00, 8'h5A, 8'h00});

        for (int i = 0; i < 4; i++) st[i] = 8'($urandom);
        fork
            for (int n = 0; n < 40; n++) begin
                a_xfer(1'($urandom), 3'($urandom), 8'($urandom));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0;
            end
            for (int n = 0; n < 40; n++) begin
                b_xfer(1'($urandom), 3'($urandom), 8'($urandom));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0;
            end
        join
        repeat (3) @(posedge clk); #1;

        // Reset lands in the grant cycle of an A write
        a_req = 1; a_we = 1; a_addr = 3'd0; a_wdata = 8'h11;
        @(posedge clk); #1;
        check("pre_rst_gnt", a_gnt, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0; a_req = 0;
        check("rst_ctrl0", c0, 8'h00);
        check("rst_noack", a_ack, 0);
        check("rst_rdata2", {a_rdata, b_rdata}, 0);
        @(posedge clk); #1;
        check("rst_idle", {a_gnt, b_gnt}, 0);
        a_xfer(1, 3'd0, 8'h22);
        check("post_rst_wr", c0, 8'h22);
        b_xfer(0, 3'd0, 8'h00);
        check("post_rst_rd", b_rdata, 8'h22);
        repeat (3) @(posedge clk); #1;
        check("sb_empty", aq.size() + bq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
